// File: rtl/hack_mem_arbiter.sv
// hack_mem_arbiter
//   Shares one single-port, 1-cycle-read SRAM (Hack data/screen memory) between
//   the Hack CPU data port and the LA-driven host loader port.
//
//   Build option: define ARB_ROUND_ROBIN_EN to replace fixed CPU priority (with
//   host starvation override) by round-robin between the two requesters.
//
// Ports:
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   loader_mode_i                1 = CPU locked out, host owns memory
//   cpu_req_i/we/addr/wdata      CPU request, held stable until cpu_gnt_o
//   cpu_gnt_o, cpu_rvalid_o      CPU grant (combinational), read-valid (N+1)
//   cpu_rdata_o                  CPU read data (mem_rdata_i)
//   host_req_i/we/addr/wdata     host request, held stable until host_gnt_o
//   host_gnt_o, host_rvalid_o    host grant, read-valid
//   host_rdata_o                 host read data (mem_rdata_i)
//   mem_en_o/we/addr/wdata       SRAM command, zero when nobody is granted
//   mem_rdata_i                  SRAM read data, valid the cycle after a read
//   starve_cnt_o                 host starvation counter (debug)
module hack_mem_arbiter #(
   parameter int unsigned ADDR_W       = 15,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              loader_mode_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic              cpu_gnt_o,
   output logic              cpu_rvalid_o,
   output logic [DATA_W-1:0] cpu_rdata_o,
   input  logic              host_req_i,
   input  logic              host_we_i,
   input  logic [ADDR_W-1:0] host_addr_i,
   input  logic [DATA_W-1:0] host_wdata_i,
   output logic              host_gnt_o,
   output logic              host_rvalid_o,
   output logic [DATA_W-1:0] host_rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [7:0]        starve_cnt_o
);

   typedef enum logic [1:0] {
      OwnNone = 2'd0,
      OwnCpu  = 2'd1,
      OwnHost = 2'd2
   } owner_e;

`ifndef ARB_ROUND_ROBIN_EN
   localparam logic [7:0] StarveLim = 8'(STARVE_LIMIT);
`endif

   owner_e     owner_q, owner_d;
   logic [7:0] starve_q, starve_d;
   logic       rd_q, rd_d;     // a read was granted last cycle
   logic       cpu_win, host_win;

   // Grant decision from current requests and registered state.
   always_comb begin
      cpu_win  = 1'b0;
      host_win = 1'b0;
      if (loader_mode_i) begin
         host_win = host_req_i;
      end else begin
`ifdef ARB_ROUND_ROBIN_EN
         if (cpu_req_i && host_req_i) begin
            // Non-owner wins; with no owner yet the CPU goes first.
            if (owner_q == OwnCpu) host_win = 1'b1;
            else                   cpu_win  = 1'b1;
         end else begin
            cpu_win  = cpu_req_i;
            host_win = host_req_i;
         end
`else
         if (host_req_i && (starve_q >= StarveLim)) begin
            host_win = 1'b1;
         end else if (cpu_req_i) begin
            cpu_win = 1'b1;
         end else begin
            host_win = host_req_i;
         end
`endif
      end
   end

   // Reset forces grants low immediately, not just at the next edge.
   assign cpu_gnt_o  = cpu_win  & wb_rst_ni;
   assign host_gnt_o = host_win & wb_rst_ni;

   // SRAM command mux.
   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (cpu_gnt_o) begin
         mem_en_o    = 1'b1;
         mem_we_o    = cpu_we_i;
         mem_addr_o  = cpu_addr_i;
         mem_wdata_o = cpu_wdata_i;
      end else if (host_gnt_o) begin
         mem_en_o    = 1'b1;
         mem_we_o    = host_we_i;
         mem_addr_o  = host_addr_i;
         mem_wdata_o = host_wdata_i;
      end
   end

   // Next-state: owner, read-pending and starvation counter.
   always_comb begin
      owner_d  = owner_q;
      rd_d     = mem_en_o & ~mem_we_o;
      starve_d = 8'd0;
      if (cpu_gnt_o) begin
         owner_d = OwnCpu;
      end else if (host_gnt_o) begin
         owner_d = OwnHost;
      end
      if (host_req_i && !host_gnt_o) begin
         starve_d = (starve_q == 8'hFF) ? starve_q : starve_q + 8'd1;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         owner_q  <= OwnNone;
         rd_q     <= 1'b0;
         starve_q <= 8'd0;
      end else begin
         owner_q  <= owner_d;
         rd_q     <= rd_d;
         starve_q <= starve_d;
      end
   end

   // owner_q names last cycle's grantee, so it routes the read-valid pulse
   // even if loader_mode_i changed since.
   assign cpu_rvalid_o  = rd_q & (owner_q == OwnCpu);
   assign host_rvalid_o = rd_q & (owner_q == OwnHost);
   assign cpu_rdata_o   = mem_rdata_i;
   assign host_rdata_o  = mem_rdata_i;
   assign starve_cnt_o  = starve_q;

endmodule

// File: tb/tb_hack_mem_arbiter.sv
module tb_hack_mem_arbiter;

   localparam int unsigned AW = 15;
   localparam int unsigned DW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          loader_mode;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt, cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          host_req, host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_gnt, host_rvalid;
   logic [DW-1:0] host_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [7:0]    starve_cnt;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] sram [0:(1<<AW)-1];

   always #5 clk = ~clk;

   // 1-cycle-read SRAM model
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) sram[mem_addr] <= mem_wdata;
         else        mem_rdata <= sram[mem_addr];
      end
   end

   hack_mem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(8)
   ) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .loader_mode_i(loader_mode),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
      .cpu_wdata_i(cpu_wdata), .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid),
      .cpu_rdata_o(cpu_rdata),
      .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
      .host_wdata_i(host_wdata), .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid),
      .host_rdata_o(host_rdata),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .starve_cnt_o(starve_cnt)
   );

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      loader_mode = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      cpu_req = 1'b1; host_req = 1'b1;
      #3;
      checks++;
      if ({cpu_gnt, host_gnt, mem_en} !== 3'b000) begin
         $display("FAIL reset_gnt: got %b want 000", {cpu_gnt, host_gnt, mem_en});
         errors++;
      end
      tick();
      idle_inputs();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_en} !== 5'b0) begin
            $display("FAIL reset_idle[%0d]: got %b want 00000", i,
                     {cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_en});
            errors++;
         end
         checks++;
         if (starve_cnt !== 8'd0) begin
            $display("FAIL reset_starve[%0d]: got %0d want 0", i, starve_cnt);
            errors++;
         end
      end
   endtask

   task automatic test_starvation();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0001;
      host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0002;
      #1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({cpu_gnt, host_gnt} !== 2'b10 || starve_cnt !== 8'(i)) begin
            $display("FAIL starve_cpu[%0d]: got gnt=%b cnt=%0d want gnt=10 cnt=%0d",
                     i, {cpu_gnt, host_gnt}, starve_cnt, i);
            errors++;
         end
         tick();
      end
      checks++;
      if ({cpu_gnt, host_gnt} !== 2'b01 || starve_cnt !== 8'd8 || mem_addr !== 15'h0002) begin
         $display("FAIL starve_host: got gnt=%b cnt=%0d addr=%h want gnt=01 cnt=8 addr=0002",
                  {cpu_gnt, host_gnt}, starve_cnt, mem_addr);
         errors++;
      end
      tick();
      checks++;
      if ({cpu_gnt, host_gnt} !== 2'b10 || starve_cnt !== 8'd0 || host_rvalid !== 1'b1) begin
         $display("FAIL starve_after: got gnt=%b cnt=%0d hrv=%b want gnt=10 cnt=0 hrv=1",
                  {cpu_gnt, host_gnt}, starve_cnt, host_rvalid);
         errors++;
      end
      idle_inputs();
      tick();
      tick();
   endtask

   task automatic test_round_robin();
      logic [1:0] want;
      cpu_req = 1'b1; host_req = 1'b1;
      cpu_addr = 15'h0001; host_addr = 15'h0002;
      #1;
      for (int i = 0; i < 6; i++) begin
         want = (i % 2 == 0) ? 2'b10 : 2'b01;
         checks++;
         if ({cpu_gnt, host_gnt} !== want) begin
            $display("FAIL rr_alt[%0d]: got %b want %b", i, {cpu_gnt, host_gnt}, want);
            errors++;
         end
         tick();
      end
      idle_inputs();
      tick();
      tick();
   endtask

   task automatic test_cpu_rw();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0010; cpu_wdata = 16'hBEEF;
      #1;
      checks++;
      if ({cpu_gnt, host_gnt, mem_en, mem_we} !== 4'b1011 || mem_addr !== 15'h0010 ||
          mem_wdata !== 16'hBEEF) begin
         $display("FAIL cpu_wr: got gnt=%b en=%b we=%b addr=%h wd=%h want 10/1/1/0010/beef",
                  {cpu_gnt, host_gnt}, mem_en, mem_we, mem_addr, mem_wdata);
         errors++;
      end
      tick();
      cpu_we = 1'b0; cpu_wdata = '0;
      #1;
      checks++;
      if (cpu_gnt !== 1'b1 || mem_we !== 1'b0 || cpu_rvalid !== 1'b0) begin
         $display("FAIL cpu_rd_gnt: got gnt=%b we=%b rv=%b want 1/0/0",
                  cpu_gnt, mem_we, cpu_rvalid);
         errors++;
      end
      tick();
      cpu_req = 1'b0;
      #1;
      checks++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hBEEF || host_rvalid !== 1'b0 ||
          mem_en !== 1'b0) begin
         $display("FAIL cpu_rdata: got rv=%b data=%h hrv=%b en=%b want 1/beef/0/0",
                  cpu_rvalid, cpu_rdata, host_rvalid, mem_en);
         errors++;
      end
      tick();
      checks++;
      if (cpu_rvalid !== 1'b0) begin
         $display("FAIL cpu_rv_pulse: got %b want 0", cpu_rvalid);
         errors++;
      end
   endtask

   task automatic test_loader();
      loader_mode = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0020; cpu_wdata = 16'h1234;
      host_req = 1'b1; host_we = 1'b1;
      for (int i = 0; i < 4; i++) begin
         host_addr = 15'(i); host_wdata = 16'h00A0 + 16'(i);
         #1;
         checks++;
         if ({cpu_gnt, host_gnt, mem_we} !== 3'b011 || mem_addr !== 15'(i) ||
             mem_wdata !== 16'h00A0 + 16'(i)) begin
            $display("FAIL loader_wr[%0d]: got gnt=%b we=%b addr=%h wd=%h", i,
                     {cpu_gnt, host_gnt}, mem_we, mem_addr, mem_wdata);
            errors++;
         end
         tick();
      end
      loader_mode = 1'b0;
      host_req = 1'b0;
      #1;
      checks++;
      if ({cpu_gnt, host_gnt} !== 2'b10 || mem_addr !== 15'h0020) begin
         $display("FAIL loader_exit: got gnt=%b addr=%h want 10/0020",
                  {cpu_gnt, host_gnt}, mem_addr);
         errors++;
      end
      tick();
      cpu_req = 1'b0; cpu_we = 1'b0;
      host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0002;
      tick();
      host_req = 1'b0;
      #1;
      checks++;
      if (host_rvalid !== 1'b1 || host_rdata !== 16'h00A2 || cpu_rvalid !== 1'b0) begin
         $display("FAIL loader_readback: got hrv=%b data=%h crv=%b want 1/00a2/0",
                  host_rvalid, host_rdata, cpu_rvalid);
         errors++;
      end
      tick();
   endtask

   task automatic test_reset_mid_read();
      host_req = 1'b1; host_we = 1'b0; host_addr = 15'h7FFF;
      #1;
      checks++;
      if (host_gnt !== 1'b1 || mem_addr !== 15'h7FFF) begin
         $display("FAIL mid_gnt: got gnt=%b addr=%h want 1/7fff", host_gnt, mem_addr);
         errors++;
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({host_gnt, mem_en} !== 2'b00) begin
         $display("FAIL mid_rst_gnt: got %b want 00", {host_gnt, mem_en});
         errors++;
      end
      tick();
      checks++;
      if ({host_rvalid, cpu_rvalid} !== 2'b00) begin
         $display("FAIL mid_rst_rvalid: got %b want 00", {host_rvalid, cpu_rvalid});
         errors++;
      end
      host_req = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if ({mem_en, host_rvalid} !== 2'b00 || starve_cnt !== 8'd0) begin
         $display("FAIL mid_idle: got en/hrv=%b cnt=%0d want 00/0", {mem_en, host_rvalid},
                  starve_cnt);
         errors++;
      end
      host_req = 1'b1;
      #1;
      checks++;
      if (host_gnt !== 1'b1) begin
         $display("FAIL mid_regrant: got %b want 1", host_gnt);
         errors++;
      end
      tick();
      host_req = 1'b0;
      #1;
      checks++;
      if (host_rvalid !== 1'b1) begin
         $display("FAIL mid_rvalid: got %b want 1", host_rvalid);
         errors++;
      end
      tick();
   endtask

   initial begin
      test_reset();
`ifdef ARB_ROUND_ROBIN_EN
      test_round_robin();
`else
      test_starvation();
`endif
      test_cpu_rw();
      test_loader();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
